dmem_sa: RTL and testbench

DMEM_SA -- requirements
Module: dmem_sa

---
 rtl/dmem_pkg.sv | 73 +++++++
 rtl/dmem_way.sv | 77 +++++++
 rtl/dmem_sa.sv | 235 +++++++++++++++++++++++
 tb/tb_dmem_sa.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the set-associative write-through data cache.
package dmem_pkg;

    // Controller states
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRefill = 2'd1,
        StWrite  = 2'd2
    } state_e;

    // len[1:0] access size encodings
    localparam logic [1:0] SzByte   = 2'd0;
    localparam logic [1:0] SzHalf   = 2'd1;
    localparam logic [1:0] SzWord   = 2'd2;
    localparam logic [1:0] SzDouble = 2'd3;

    // len[2] load extension encodings
    localparam logic ExtSign = 1'b0;
    localparam logic ExtZero = 1'b1;

    // Byte-offset bits within a line
    function automatic int unsigned off_bits(input int unsigned line);
        return $clog2(line / 8);
    endfunction

    // Set-index bits
    function automatic int unsigned idx_bits(input int unsigned sets);
        return $clog2(sets);
    endfunction

    // Block-address bits (address above the line offset)
    function automatic int unsigned blk_bits(input int unsigned line);
        return 64 - off_bits(line);
    endfunction

    // Width of a way pointer; at least one bit even for a direct-mapped cache
    function automatic int unsigned ptr_bits(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Low address bits that must be zero for an aligned access
    function automatic logic [2:0] align_mask(input logic [1:0] sz);
        case (sz)
            SzByte:  return 3'b000;
            SzHalf:  return 3'b001;
            SzWord:  return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // Byte enables of an access starting at lane 0
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            SzByte:  return 8'h01;
            SzHalf:  return 8'h03;
            SzWord:  return 8'h0f;
            default: return 8'hff;
        endcase
    endfunction

    // Sign- or zero-extend a right-aligned load value
    function automatic logic [63:0] extend(input logic [63:0] lane, input logic [2:0] len);
        logic zext;
        zext = (len[2] == ExtZero);
        case (len[1:0])
            SzByte:  return zext ? {56'd0, lane[7:0]}  : {{56{lane[7]}}, lane[7:0]};
            SzHalf:  return zext ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            SzWord:  return zext ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            default: return lane;
        endcase
    endfunction

endpackage

// File: rtl/dmem_way.sv
// One cache way: valid bits, tags and line data for every set.
module dmem_way
    import dmem_pkg::*;
#(
    parameter int unsigned SETS = 64,
    parameter int unsigned LINE = 256,
    localparam int unsigned OFF = off_bits(LINE),
    localparam int unsigned IDX = idx_bits(SETS),
    localparam int unsigned TAG = 64 - OFF - IDX
) (
    input  logic            clk,
    input  logic            rst_n,
    // Set addressed by the current request (read, fill and store)
    input  logic [IDX-1:0]  idx,
    output logic            rd_valid,
    output logic [TAG-1:0]  rd_tag,
    output logic [LINE-1:0] rd_line,
    // Line install
    input  logic            fill_en,
    input  logic            fill_valid,
    input  logic [TAG-1:0]  fill_tag,
    input  logic [LINE-1:0] fill_line,
    // Store-hit byte update; st_word selects the 64-bit word in the line
    input  logic            st_en,
    input  logic [OFF-1:0]  st_word,
    input  logic [63:0]     st_data,
    input  logic [7:0]      st_mask,
    // Snoop invalidation
    input  logic            inv_en,
    input  logic [IDX-1:0]  inv_idx,
    input  logic [TAG-1:0]  inv_tag
);

    logic [SETS-1:0] valid_q, valid_d;
    logic [TAG-1:0]  tag_q  [SETS];
    logic [LINE-1:0] data_q [SETS];

    assign rd_valid = valid_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_line  = data_q[idx];

    // Valid next-state: an install owns its set, a snoop may clear any other set
    always_comb begin
        valid_d = valid_q;
        for (int s = 0; s < SETS; s++) begin
            if (fill_en && idx == IDX'(s)) begin
                valid_d[s] = fill_valid;
            end else if (inv_en && inv_idx == IDX'(s) && tag_q[s] == inv_tag) begin
                valid_d[s] = 1'b0;
            end
        end
    end

    // Valid bits are the only state that must be reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays: whole-line install or byte-masked store update
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[idx]  <= fill_tag;
            data_q[idx] <= fill_line;
        end else if (st_en) begin
            for (int b = 0; b < 8; b++) begin
                if (st_mask[b]) begin
                    data_q[idx][32'(st_word) * 64 + b * 8 +: 8] <= st_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dmem_sa.sv
// Set-associative write-through, no-write-allocate data cache with snoop invalidation.
module dmem_sa
    import dmem_pkg::*;
#(
    parameter int unsigned SETS = 64,
    parameter int unsigned WAYS = 2,
    parameter int unsigned LINE = 256,
    localparam int unsigned BLK = blk_bits(LINE)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [63:0]     addr,
    input  logic [63:0]     data_in,
    input  logic [2:0]      len,
    input  logic            rd,
    input  logic            wr,
    output logic [63:0]     data_out,
    output logic            ld_ma,
    output logic            st_ma,
    output logic            stall_dmem,
    output logic [BLK-1:0]  b_addr_d,
    output logic            b_rd_d,
    input  logic [LINE-1:0] b_data_in_d,
    input  logic            b_dv_d,
    output logic            b_wr_d,
    output logic [63:0]     b_data_out_d,
    output logic [7:0]      b_wmask_d,
    input  logic            b_ack_d,
    input  logic [BLK-1:0]  inv_addr,
    input  logic            inv
);

    localparam int unsigned OFF = off_bits(LINE);
    localparam int unsigned IDX = idx_bits(SETS);
    localparam int unsigned TAG = BLK - IDX;
    localparam int unsigned PTR = ptr_bits(WAYS);

    // Request decode
    logic [IDX-1:0] idx;
    logic [TAG-1:0] tag;
    logic [OFF-1:0] byte_off;
    logic [OFF-1:0] word_num;
    logic           misal;
    logic           ld_req;
    logic           st_req;

    assign idx      = addr[OFF+IDX-1:OFF];
    assign tag      = addr[63:OFF+IDX];
    assign byte_off = addr[OFF-1:0];
    assign word_num = byte_off >> 3;
    assign misal    = |(addr[2:0] & align_mask(len[1:0]));
    // A store takes precedence over a simultaneous load
    assign st_req   = wr && !misal;
    assign ld_req   = rd && !wr && !misal;

    state_e state_q, state_d;

    // Way array interface
    logic [WAYS-1:0] way_valid;
    logic [TAG-1:0]  way_tag  [WAYS];
    logic [LINE-1:0] way_line [WAYS];
    logic [WAYS-1:0] way_hit;
    logic [WAYS-1:0] way_fill;
    logic [WAYS-1:0] way_st;
    logic [LINE-1:0] hit_line;
    logic            hit;

    // Install / store control
    logic            fill_go;
    logic            fill_valid;
    logic            st_go;
    logic [PTR-1:0]  victim;
    logic            use_rr;
    logic [PTR-1:0]  rr_q [SETS];
    logic [PTR-1:0]  rr_next;

    // Load result path
    logic [63:0]     word;
    logic [63:0]     lane;

    assign fill_go    = (state_q == StRefill) && b_dv_d;
    // A snoop hitting the block in flight makes the install land invalid
    assign fill_valid = !(inv && inv_addr == addr[63:OFF]);
    assign st_go      = (state_q == StWrite) && b_ack_d;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign way_fill[w] = fill_go && (victim == PTR'(w));
        assign way_st[w]   = st_go && way_hit[w];

        dmem_way #(
            .SETS (SETS),
            .LINE (LINE)
        ) u_way (
            .clk        (clk),
            .rst_n      (rst_n),
            .idx        (idx),
            .rd_valid   (way_valid[w]),
            .rd_tag     (way_tag[w]),
            .rd_line    (way_line[w]),
            .fill_en    (way_fill[w]),
            .fill_valid (fill_valid),
            .fill_tag   (tag),
            .fill_line  (b_data_in_d),
            .st_en      (way_st[w]),
            .st_word    (word_num),
            .st_data    (b_data_out_d),
            .st_mask    (b_wmask_d),
            .inv_en     (inv),
            .inv_idx    (inv_addr[IDX-1:0]),
            .inv_tag    (inv_addr[BLK-1:IDX])
        );
    end

    // Tag compare across all ways and merge of the hitting line
    always_comb begin
        hit_line = '0;
        way_hit  = '0;
        for (int w = 0; w < WAYS; w++) begin
            way_hit[w] = way_valid[w] && (way_tag[w] == tag);
            if (way_hit[w]) begin
                hit_line = hit_line | way_line[w];
            end
        end
    end

    assign hit = |way_hit;

    // Victim: lowest-index invalid way, else the set's round-robin pointer
    always_comb begin
        victim = rr_q[idx];
        use_rr = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) begin
                victim = PTR'(w);
                use_rr = 1'b0;
            end
        end
    end

    assign rr_next = (rr_q[idx] == PTR'(WAYS - 1)) ? '0 : rr_q[idx] + 1'b1;

    // Round-robin pointers advance only when they chose the victim
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
            end
        end else if (fill_go && use_rr) begin
            rr_q[idx] <= rr_next;
        end
    end

    // Pick the addressed word, then the addressed lane within it
    assign word = 64'(hit_line >> {word_num, 6'd0});
    assign lane = word >> {addr[2:0], 3'd0};

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (st_req) begin
                    state_d = StWrite;
                end else if (ld_req && !hit) begin
                    state_d = StRefill;
                end
            end
            StRefill: begin
                if (b_dv_d) begin
                    state_d = StIdle;
                end
            end
            StWrite: begin
                if (b_ack_d) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; everything is forced low while reset is asserted
    always_comb begin
        data_out     = '0;
        ld_ma        = 1'b0;
        st_ma        = 1'b0;
        stall_dmem   = 1'b0;
        b_addr_d     = '0;
        b_rd_d       = 1'b0;
        b_wr_d       = 1'b0;
        b_data_out_d = '0;
        b_wmask_d    = '0;
        if (rst_n) begin
            ld_ma = rd && !wr && misal;
            st_ma = wr && misal;
            unique case (state_q)
                StIdle: begin
                    if (st_req) begin
                        stall_dmem = 1'b1;
                    end else if (ld_req) begin
                        if (hit) begin
                            data_out = extend(lane, len);
                        end else begin
                            stall_dmem = 1'b1;
                        end
                    end
                end
                StRefill: begin
                    stall_dmem = 1'b1;
                    b_rd_d     = 1'b1;
                    b_addr_d   = addr[63:OFF];
                end
                StWrite: begin
                    // The store retires in the ack cycle, so the requester is released then
                    stall_dmem   = !b_ack_d;
                    b_wr_d       = 1'b1;
                    b_addr_d     = addr[63:OFF];
                    b_data_out_d = data_in << {addr[2:0], 3'd0};
                    b_wmask_d    = size_mask(len[1:0]) << addr[2:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_sa.sv
// Directed self-checking bench for dmem_sa (SETS=64, WAYS=2, LINE=256).
module tb_dmem_sa;

    localparam int unsigned BLK = 59;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [63:0]    addr;
    logic [63:0]    data_in;
    logic [2:0]     len;
    logic           rd;
    logic           wr;
    logic [63:0]    data_out;
    logic           ld_ma;
    logic           st_ma;
    logic           stall_dmem;
    logic [BLK-1:0] b_addr_d;
    logic           b_rd_d;
    logic [255:0]   b_data_in_d;
    logic           b_dv_d;
    logic           b_wr_d;
    logic [63:0]    b_data_out_d;
    logic [7:0]     b_wmask_d;
    logic           b_ack_d;
    logic [BLK-1:0] inv_addr;
    logic           inv;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_sa u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .addr         (addr),
        .data_in      (data_in),
        .len          (len),
        .rd           (rd),
        .wr           (wr),
        .data_out     (data_out),
        .ld_ma        (ld_ma),
        .st_ma        (st_ma),
        .stall_dmem   (stall_dmem),
        .b_addr_d     (b_addr_d),
        .b_rd_d       (b_rd_d),
        .b_data_in_d  (b_data_in_d),
        .b_dv_d       (b_dv_d),
        .b_wr_d       (b_wr_d),
        .b_data_out_d (b_data_out_d),
        .b_wmask_d    (b_wmask_d),
        .b_ack_d      (b_ack_d),
        .inv_addr     (inv_addr),
        .inv          (inv)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bus memory image: byte i of block b is b[7:0] ^ (i * 0x11)
    function automatic logic [255:0] line_of(input logic [63:0] blk);
        logic [255:0] l;
        for (int i = 0; i < 32; i++) begin
            l[i*8 +: 8] = blk[7:0] ^ 8'(i * 17);
        end
        return l;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold a load until stall drops; the bus answers on the lat-th b_rd_d cycle
    task automatic run_load(input logic [63:0] a, input logic [2:0] ln, input int lat,
                            input bit kill, output logic [63:0] dout, output int stalls,
                            output int refills);
        int  rd_cyc = 0;
        int  cyc = 0;
        bit  done = 0;
        bit  killed = 0;
        dout = '0;
        stalls = 0;
        refills = 0;
        addr = a;
        len = ln;
        rd = 1'b1;
        wr = 1'b0;
        while (!done && cyc < 60) begin
            #1;
            if (b_rd_d) begin
                if (rd_cyc == 0) begin
                    refills++;
                    check($sformatf("b_addr_d@%h", a), 64'(b_addr_d), a >> 5);
                    check("rd_wr_excl", {63'd0, b_wr_d}, 64'd0);
                end
                rd_cyc++;
                if (rd_cyc == lat) begin
                    b_data_in_d = line_of(a >> 5);
                    b_dv_d = 1'b1;
                    rd_cyc = 0;
                    if (kill && !killed) begin
                        inv = 1'b1;
                        inv_addr = BLK'(a >> 5);
                        killed = 1;
                    end
                end
            end
            #1;
            if (!stall_dmem) begin
                dout = data_out;
                done = 1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
            b_dv_d = 1'b0;
            inv = 1'b0;
            cyc++;
        end
        rd = 1'b0;
        check($sformatf("ld_done@%h", a), {63'd0, done}, 64'd1);
    endtask

    // Hold a store until stall drops; ack on the lat-th b_wr_d cycle
    task automatic run_store(input logic [63:0] a, input logic [2:0] ln, input logic [63:0] d,
                             input bit also_rd, input int lat, input logic [7:0] exp_mask,
                             input logic [63:0] exp_data, output int stalls);
        int wr_cyc = 0;
        int cyc = 0;
        bit done = 0;
        bit saw_rd = 0;
        stalls = 0;
        addr = a;
        len = ln;
        data_in = d;
        rd = also_rd;
        wr = 1'b1;
        while (!done && cyc < 60) begin
            #1;
            if (b_rd_d) saw_rd = 1;
            if (b_wr_d) begin
                if (wr_cyc == 0) begin
                    check($sformatf("st_b_addr@%h", a), 64'(b_addr_d), a >> 5);
                    check($sformatf("st_wmask@%h", a), 64'(b_wmask_d), 64'(exp_mask));
                    check($sformatf("st_wdata@%h", a), b_data_out_d, exp_data);
                end
                wr_cyc++;
                if (wr_cyc == lat) b_ack_d = 1'b1;
            end
            #1;
            if (!stall_dmem) done = 1;
            else stalls++;
            @(posedge clk);
            #1;
            b_ack_d = 1'b0;
            cyc++;
        end
        rd = 1'b0;
        wr = 1'b0;
        check($sformatf("st_done@%h", a), {63'd0, done}, 64'd1);
        check($sformatf("st_no_rd@%h", a), {63'd0, saw_rd}, 64'd0);
    endtask

    // Hit table after 0x1000 is filled: address, len, expected data_out
    logic [63:0] h_addr [8] = '{64'h1004, 64'h1004, 64'h1002, 64'h1000,
                                64'h1001, 64'h1008, 64'h1018, 64'h1006};
    logic [2:0]  h_len  [8] = '{3'b010, 3'b110, 3'b001, 3'b101,
                                3'b100, 3'b011, 3'b011, 3'b000};
    logic [63:0] h_exp  [8] = '{64'hFFFFFFFF_F7E6D5C4, 64'h00000000_F7E6D5C4,
                                64'hFFFFFFFF_FFFFB3A2, 64'h00000000_00009180,
                                64'h00000000_00000091, 64'h7F6E5D4C_3B2A1908,
                                64'h8F7E6D5C_4B3A2918, 64'hFFFFFFFF_FFFFFFE6};

    initial begin
        logic [63:0] dout;
        int          stalls;
        int          refills;

        rst_n = 1'b0;
        addr = 64'h1003;
        data_in = '0;
        len = 3'b001;
        rd = 1'b1;
        wr = 1'b0;
        b_data_in_d = '0;
        b_dv_d = 1'b0;
        b_ack_d = 1'b0;
        inv_addr = '0;
        inv = 1'b0;

        // Outputs stay low in reset even with a misaligned request applied
        #2;
        check("rst_ld_ma", {63'd0, ld_ma}, 64'd0);
        check("rst_stall", {63'd0, stall_dmem}, 64'd0);
        rd = 1'b0;
        wr = 1'b1;
        addr = 64'h1006;
        len = 3'b010;
        #1;
        check("rst_st_ma", {63'd0, st_ma}, 64'd0);
        check("rst_b_wr", {63'd0, b_wr_d}, 64'd0);
        wr = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("idle_data_out", data_out, 64'd0);
        check("idle_b_addr", 64'(b_addr_d), 64'd0);

        // Misaligned load and store flag in the same cycle with no bus activity
        addr = 64'h1003;
        len = 3'b001;
        rd = 1'b1;
        #1;
        check("ld_ma", {63'd0, ld_ma}, 64'd1);
        check("ld_ma_stall", {63'd0, stall_dmem}, 64'd0);
        step();
        check("ld_ma_b_rd", {63'd0, b_rd_d}, 64'd0);
        rd = 1'b0;
        wr = 1'b1;
        addr = 64'h1006;
        len = 3'b010;
        #1;
        check("st_ma", {63'd0, st_ma}, 64'd1);
        check("st_ma_stall", {63'd0, stall_dmem}, 64'd0);
        step();
        check("st_ma_b_wr", {63'd0, b_wr_d}, 64'd0);
        wr = 1'b0;
        step();

        // Cold load D at 0x1000: four bus cycles plus one
        run_load(64'h1000, 3'b011, 4, 0, dout, stalls, refills);
        check("cold_stalls", 64'(stalls), 64'd5);
        check("cold_refills", 64'(refills), 64'd1);
        check("cold_data", dout, 64'hF7E6D5C4_B3A29180);

        // Hits of every size and extension
        for (int i = 0; i < 8; i++) begin
            run_load(h_addr[i], h_len[i], 1, 0, dout, stalls, refills);
            check($sformatf("hit_data%0d", i), dout, h_exp[i]);
            check($sformatf("hit_stalls%0d", i), 64'(stalls), 64'd0);
        end

        // Store-hit byte, then read it back signed and check neighbours
        run_store(64'h1005, 3'b000, 64'hA5, 0, 3, 8'h20, 64'h0000A500_00000000, stalls);
        check("stb_stalls", 64'(stalls), 64'd3);
        run_load(64'h1005, 3'b000, 1, 0, dout, stalls, refills);
        check("stb_readback", dout, 64'hFFFFFFFF_FFFFFFA5);
        run_load(64'h1000, 3'b011, 1, 0, dout, stalls, refills);
        check("stb_neighbours", dout, 64'hF7E6A5C4_B3A29180);

        // Store miss with rd also high: store wins, no allocation
        run_store(64'h3022, 3'b001, 64'h1234, 1, 2, 8'h0C, 64'h00000000_12340000, stalls);
        run_load(64'h3020, 3'b011, 2, 0, dout, stalls, refills);
        check("stmiss_refills", 64'(refills), 64'd1);
        check("stmiss_stalls", 64'(stalls), 64'd3);
        check("stmiss_data", dout, 64'hF6E7D4C5_B2A39081);

        // Store D hit, full mask
        run_store(64'h1018, 3'b011, 64'h11223344_55667788, 0, 1, 8'hFF,
                  64'h11223344_55667788, stalls);
        check("std_stalls", 64'(stalls), 64'd1);
        run_load(64'h1018, 3'b011, 1, 0, dout, stalls, refills);
        check("std_readback", dout, 64'h11223344_55667788);

        // Three blocks in set 0: third refill evicts way 0 (block 0x80)
        run_load(64'h1800, 3'b011, 2, 0, dout, stalls, refills);
        check("set0_b_refills", 64'(refills), 64'd1);
        check("set0_b_data", dout, 64'hB7A69584_F3E2D1C0);
        run_load(64'h2000, 3'b011, 2, 0, dout, stalls, refills);
        check("set0_c_refills", 64'(refills), 64'd1);
        check("set0_c_data", dout, 64'h77665544_33221100);
        run_load(64'h1800, 3'b011, 2, 0, dout, stalls, refills);
        check("set0_b_rehit", 64'(refills), 64'd0);
        run_load(64'h1000, 3'b011, 2, 0, dout, stalls, refills);
        check("set0_a_remiss", 64'(refills), 64'd1);
        check("set0_a_data", dout, 64'hF7E6D5C4_B3A29180);

        // Idle snoop on block 0x80 leaves the other way of the set intact
        inv_addr = BLK'(64'h80);
        inv = 1'b1;
        step();
        inv = 1'b0;
        run_load(64'h2000, 3'b011, 2, 0, dout, stalls, refills);
        check("inv_other_hit", 64'(refills), 64'd0);

        // Snoop in the b_dv_d cycle: installed invalid, refill reissued
        run_load(64'h1000, 3'b011, 4, 1, dout, stalls, refills);
        check("inv_fill_refills", 64'(refills), 64'd2);
        check("inv_fill_stalls", 64'(stalls), 64'd10);
        check("inv_fill_data", dout, 64'hF7E6D5C4_B3A29180);

        // Stray b_dv_d in IDLE must not install anything
        addr = 64'h5060;
        len = 3'b011;
        b_data_in_d = line_of(64'h283);
        b_dv_d = 1'b1;
        step();
        b_dv_d = 1'b0;
        run_load(64'h5060, 3'b011, 1, 0, dout, stalls, refills);
        check("stray_dv_refills", 64'(refills), 64'd1);
        check("stray_dv_stalls", 64'(stalls), 64'd2);
        check("stray_dv_data", dout, 64'hF4E5D6C7_B0A19283);

        // Reset in the middle of a refill drops the bus request at once
        addr = 64'h4040;
        len = 3'b011;
        rd = 1'b1;
        #1;
        check("mid_rst_miss", {63'd0, stall_dmem}, 64'd1);
        step();
        check("mid_rst_b_rd_before", {63'd0, b_rd_d}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_b_rd", {63'd0, b_rd_d}, 64'd0);
        check("mid_rst_stall", {63'd0, stall_dmem}, 64'd0);
        rd = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        run_load(64'h4040, 3'b011, 3, 0, dout, stalls, refills);
        check("post_rst_refills", 64'(refills), 64'd1);
        check("post_rst_stalls", 64'(stalls), 64'd4);
        check("post_rst_data", dout, 64'h75645746_31201302);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
